// File: rtl/bridge_data_loader.sv
// Captures in-window APF bridge writes into a small FIFO and replays each
// byte-swapped 32-bit word as two 16-bit writes on a valid/ready memory port.
module bridge_data_loader #(
    parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hF000_0000,
    parameter logic [31:0] STATUS_ADDR = 32'hF100_0000,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_rd,
    output logic [31:0] bridge_rd_data,
    output logic [27:0] mem_addr,
    output logic [15:0] mem_wr_data,
    output logic        mem_wr,
    input  logic        mem_ready,
    output logic        busy,
    output logic        overflow,
    output logic [1:0]  dbg_state
);

    // Memory handshake: a halfword transfers on a rising edge where mem_wr and
    // mem_ready are both high; until then mem_wr/mem_addr/mem_wr_data hold.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 28 + 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t         state;
    state_t         next_state;

    logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic [27:0]    out_addr;
    logic [31:0]    out_data;

    logic           in_window;
    logic           push_req;
    logic           push_ok;
    logic           drop;
    logic           pop;
    logic           fifo_empty;
    logic [31:0]    swapped;
    logic [31:0]    count_ext;
    logic [3:0]     count_sat;
    logic [31:0]    status_word;

    assign in_window  = (bridge_addr & ADDR_MASK) == ADDR_BASE;
    assign push_req   = bridge_wr && in_window;
    assign fifo_empty = (count == '0);
    assign swapped    = {bridge_wr_data[7:0], bridge_wr_data[15:8],
                         bridge_wr_data[23:16], bridge_wr_data[31:24]};

    // A full FIFO can still take a word when the output stage pops this cycle.
    assign push_ok = push_req && ((count < CW'(FIFO_DEPTH)) || pop);
    assign drop    = push_req && !push_ok;

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = LO;
                end
            end
            LO: begin
                if (mem_ready) begin
                    next_state = HI;
                end
            end
            HI: begin
                if (mem_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = LO;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {bridge_addr[27:0], swapped};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            out_addr       <= '0;
            out_data       <= '0;
            overflow       <= 1'b0;
            bridge_rd_data <= '0;
        end else begin
            state <= next_state;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                out_addr <= fifo_mem[rd_ptr][59:32];
                out_data <= fifo_mem[rd_ptr][31:0];
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            bridge_rd_data <= (bridge_rd && (bridge_addr == STATUS_ADDR)) ? status_word : 32'd0;
        end
    end

    assign count_ext   = 32'(count);
    assign count_sat   = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    assign status_word = {26'd0, count_sat, overflow, busy};

    // High half sits at A+2; the 28-bit add wraps on its own.
    always_comb begin
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state)
            LO: begin
                mem_wr      = 1'b1;
                mem_addr    = out_addr;
                mem_wr_data = out_data[15:0];
            end
            HI: begin
                mem_wr      = 1'b1;
                mem_addr    = out_addr + 28'd2;
                mem_wr_data = out_data[31:16];
            end
            default: begin
                mem_wr = 1'b0;
            end
        endcase
    end

    assign busy      = !fifo_empty || (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_bridge_data_loader.sv
// Self-checking bench for bridge_data_loader: scoreboard of expected halfword
// writes, handshake-hold monitor, status reads, overflow and reset scenarios.
module tb_bridge_data_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bridge_addr;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;
    logic [27:0] mem_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr;
    logic        mem_ready;
    logic        busy;
    logic        overflow;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int xfer_cnt = 0;

    logic [43:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [27:0] prev_addr;
    logic [15:0] prev_data;

    bridge_data_loader dut (
        .clk            (clk),
        .reset          (reset),
        .bridge_addr    (bridge_addr),
        .bridge_wr      (bridge_wr),
        .bridge_wr_data (bridge_wr_data),
        .bridge_rd      (bridge_rd),
        .bridge_rd_data (bridge_rd_data),
        .mem_addr       (mem_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_wr         (mem_wr),
        .mem_ready      (mem_ready),
        .busy           (busy),
        .overflow       (overflow),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // All driver tasks start and end 1ns after a rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input bit kept);
        logic [31:0] s;
        logic [27:0] base;
        s    = swap32(d);
        base = a[27:0];
        bridge_addr    = a;
        bridge_wr_data = d;
        bridge_wr      = 1'b1;
        if (kept) begin
            exp_q.push_back({base, s[15:0]});
            exp_q.push_back({base + 28'd2, s[31:16]});
        end
        @(posedge clk); #1;
        bridge_wr = 1'b0;
    endtask

    task automatic status_read(input logic [31:0] a, output logic [31:0] d);
        bridge_addr = a;
        bridge_rd   = 1'b1;
        @(posedge clk); #1;
        bridge_rd = 1'b0;
        @(negedge clk);
        d = bridge_rd_data;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input int limit);
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < limit) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard monitor: sample mid-cycle, transfer happens at the next edge
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_wr",   64'(mem_wr),      64'd1);
                chk("hold_addr", 64'(mem_addr),    64'(prev_addr));
                chk("hold_data", 64'(mem_wr_data), 64'(prev_data));
            end
            if (mem_wr && mem_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexp_xfer", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("xfer", 64'({mem_addr, mem_wr_data}), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = mem_wr && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wr_data;
        end
    end

    initial begin
        logic [31:0] rd;
        int base;
        int g;

        reset          = 1'b1;
        bridge_addr    = '0;
        bridge_wr      = 1'b0;
        bridge_wr_data = '0;
        bridge_rd      = 1'b0;
        mem_ready      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_mem_wr",   64'(mem_wr),         64'd0);
        chk("rst_mem_addr", 64'(mem_addr),       64'd0);
        chk("rst_mem_data", 64'(mem_wr_data),    64'd0);
        chk("rst_busy",     64'(busy),           64'd0);
        chk("rst_overflow", 64'(overflow),       64'd0);
        chk("rst_rd_data",  64'(bridge_rd_data), 64'd0);
        chk("rst_state",    64'(dbg_state),      64'd0);
        @(posedge clk); #1;

        // single in-window word with latency checks
        bus_write(32'h1000_0010, 32'h1122_3344, 1'b1);
        @(negedge clk);
        chk("s1_n1_wr",   64'(mem_wr), 64'd0);
        chk("s1_n1_busy", 64'(busy),   64'd1);
        @(negedge clk);
        chk("s1_n2_wr",   64'(mem_wr),      64'd1);
        chk("s1_n2_addr", 64'(mem_addr),    64'h000_0010);
        chk("s1_n2_data", 64'(mem_wr_data), 64'h2211);
        @(negedge clk);
        chk("s1_n3_addr", 64'(mem_addr),    64'h000_0012);
        chk("s1_n3_data", 64'(mem_wr_data), 64'h4433);
        @(negedge clk);
        chk("s1_n4_busy", 64'(busy),     64'd0);
        chk("s1_n4_ovf",  64'(overflow), 64'd0);
        @(posedge clk); #1;

        // address wrap of the high half
        bus_write(32'h1FFF_FFFE, 32'h0102_0304, 1'b1);
        wait_drain(20);

        // out-of-window write is ignored
        base = xfer_cnt;
        bus_write(32'h2000_0000, 32'hDEAD_BEEF, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("s2_wr",   64'(mem_wr), 64'd0);
            chk("s2_busy", 64'(busy),   64'd0);
        end
        @(posedge clk); #1;
        status_read(32'hF100_0000, rd);
        chk("s2_status", 64'(rd), 64'd0);
        chk("s2_xfers", 64'(xfer_cnt - base), 64'd0);

        // randomised single words with random ready
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = 32'h1000_0000 | ($urandom_range(0, 32'h0FFF_FFFF) & 32'h0FFF_FFFC);
            mem_ready = ($urandom_range(0, 1) == 1);
            bus_write(a, $urandom, 1'b1);
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk); #1;
            end
            mem_ready = 1'b1;
            wait_drain(20);
        end

        // stall while the high half is presented
        mem_ready = 1'b1;
        base = xfer_cnt;
        bus_write(32'h1000_0100, 32'hA1B2_C3D4, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("s4_state_hi", 64'(dbg_state), 64'd2);
        @(posedge clk); #1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        wait_drain(10);
        chk("s4_xfers", 64'(xfer_cnt - base), 64'd2);

        // overflow: stalled sink, ten back-to-back writes
        mem_ready = 1'b0;
        base = xfer_cnt;
        for (int i = 1; i <= 10; i++) begin
            bus_write(32'h1000_0000 + 32'(4 * i), 32'(i), (i <= 9));
        end
        @(negedge clk);
        chk("s3_ovf",  64'(overflow), 64'd1);
        chk("s3_busy", 64'(busy),     64'd1);
        @(posedge clk); #1;
        status_read(32'hF100_0000, rd);
        chk("s3_status_full", 64'(rd), 64'h23);

        // release for four words, leaving four queued
        mem_ready = 1'b1;
        g = 0;
        while ((xfer_cnt - base) < 8 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        mem_ready = 1'b0;
        chk("s5_partial", 64'(xfer_cnt - base), 64'd8);
        status_read(32'hF100_0000, rd);
        chk("s5_status", 64'(rd), 64'h13);
        status_read(32'h1000_0000, rd);
        chk("s5_other_addr", 64'(rd), 64'd0);
        mem_ready = 1'b1;
        wait_drain(100);
        chk("s3_xfers", 64'(xfer_cnt - base), 64'd18);
        chk("s3_ovf_end", 64'(overflow), 64'd1);

        // reset while in LO with three words queued
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_write(32'h1000_0200 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b1);
        end
        @(negedge clk);
        chk("s6_state_lo", 64'(dbg_state), 64'd1);
        @(posedge clk); #1;
        status_read(32'hF100_0000, rd);
        chk("s6_status_pre", 64'(rd), 64'h0F);
        do_reset();
        @(negedge clk);
        chk("s6_wr",   64'(mem_wr),   64'd0);
        chk("s6_busy", 64'(busy),     64'd0);
        chk("s6_ovf",  64'(overflow), 64'd0);
        @(posedge clk); #1;
        status_read(32'hF100_0000, rd);
        chk("s6_status_post", 64'(rd), 64'd0);

        mem_ready = 1'b1;
        bus_write(32'h1000_0010, 32'h1122_3344, 1'b1);
        @(negedge clk);
        chk("s6b_n1_wr", 64'(mem_wr), 64'd0);
        @(negedge clk);
        chk("s6b_n2_wr",   64'(mem_wr),      64'd1);
        chk("s6b_n2_addr", 64'(mem_addr),    64'h000_0010);
        chk("s6b_n2_data", 64'(mem_wr_data), 64'h2211);
        @(negedge clk);
        chk("s6b_n3_addr", 64'(mem_addr),    64'h000_0012);
        chk("s6b_n3_data", 64'(mem_wr_data), 64'h4433);
        @(negedge clk);
        chk("s6b_n4_busy", 64'(busy),     64'd0);
        chk("s6b_n4_ovf",  64'(overflow), 64'd0);
        chk("final_q", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
